// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: FSM encoding and default widths.
package regfile_sb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register check, write bypass and busy lookup.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   run_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic [DATA_W-1:0]      entry_i,
  input  logic [2**ADDR_W-1:0]   busy_vec_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   busy_o
);

  logic is_zero;
  logic bypass;

  assign is_zero = (ZERO_REG != 0) && (addr_i == '0);
  assign bypass  = we_i && (wr_addr_i == addr_i);

  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    if (run_i && !is_zero) begin
      // A same-cycle writeback both supplies the value and resolves the hazard.
      if (bypass) begin
        data_o = wr_data_i;
      end else begin
        data_o = entry_i;
        busy_o = busy_vec_i[addr_i];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write bypass, per-register busy scoreboard and post-reset clear sweep.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim,
  input  logic [ADDR_W-1:0]        claim_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic wr_ok;
  logic claim_ok;

  assign run      = (state_q == ST_RUN);
  assign ready    = run;
  assign wr_ok    = run && we && !((ZERO_REG != 0) && (wr_addr == '0));
  assign claim_ok = run && claim && !((ZERO_REG != 0) && (claim_addr == '0));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (!run) begin
      // Counter holds at the last entry so it never wraps within a sweep.
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  // Claim is applied after the write so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_sb_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .run_i      (run),
      .addr_i     (addr),
      .we_i       (we),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .entry_i    (mem_q[addr]),
      .busy_vec_i (busy_q),
      .data_o     (rd_data[i*DATA_W +: DATA_W]),
      .busy_o     (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: two instances (ZERO_REG 1 and 0) against an array model.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              claim;
  logic [AW-1:0]     claim_addr;

  // Index 1: ZERO_REG = 1, index 0: ZERO_REG = 0.
  logic              rdy    [2];
  logic [NRD*DW-1:0] rdata  [2];
  logic [NRD-1:0]    rbusy  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_mem  [2][DEPTH];
  bit          m_busy [2][DEPTH];

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NRD), .ZERO_REG (1)
  ) u_dut_z (
    .clk        (clk),
    .reset      (reset),
    .ready      (rdy[1]),
    .rd_addr    (rd_addr),
    .rd_data    (rdata[1]),
    .rd_busy    (rbusy[1]),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim      (claim),
    .claim_addr (claim_addr)
  );

  regfile_sb #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NRD), .ZERO_REG (0)
  ) u_dut_n (
    .clk        (clk),
    .reset      (reset),
    .ready      (rdy[0]),
    .rd_addr    (rd_addr),
    .rd_data    (rdata[0]),
    .rd_busy    (rbusy[0]),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim      (claim),
    .claim_addr (claim_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void predict(input int z, input logic [AW-1:0] a,
                                  output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (!m_run) return;
    if (z == 1 && a == 0) return;
    if (we && wr_addr == a) begin
      d = wr_data;
      return;
    end
    d = m_mem[z][a];
    b = m_busy[z][a];
  endfunction

  task automatic check_all();
    logic [31:0] d;
    logic        b;
    logic [AW-1:0] a;
    for (int z = 0; z < 2; z++) begin
      check_eq($sformatf("z%0d_ready", z), {31'd0, rdy[z]}, {31'd0, m_run});
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        predict(z, a, d, b);
        check_eq($sformatf("z%0d_p%0d_data_a%0d", z, p, a), rdata[z][p*DW +: DW], d);
        check_eq($sformatf("z%0d_p%0d_busy_a%0d", z, p, a), {31'd0, rbusy[z][p]}, {31'd0, b});
      end
    end
  endtask

  task automatic model_edge();
    bit wz, cz;
    if (reset) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < DEPTH; i++) m_busy[z][i] = 1'b0;
    end else if (!m_run) begin
      for (int z = 0; z < 2; z++) m_mem[z][m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      for (int z = 0; z < 2; z++) begin
        wz = we && !(z == 1 && wr_addr == 0);
        cz = claim && !(z == 1 && claim_addr == 0);
        if (wz) begin
          m_mem[z][wr_addr]  = wr_data;
          m_busy[z][wr_addr] = 1'b0;
        end
        if (cz) m_busy[z][claim_addr] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    claim = 1'b0; claim_addr = '0;
  endtask

  initial begin
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[z][i]  = '0;
        m_busy[z][i] = 1'b0;
      end
    reset = 1'b1;
    idle_inputs();
    set_rd(0, 0);
    // First reset edge: DUT state is unknown before it, so no checks.
    @(posedge clk);
    model_edge();
    #1;

    // 1: sweep timing, then every address reads 0 / not busy.
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      set_rd(AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)));
      cycle();
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      cycle();
    end

    // 2: write then read on both ports; same-cycle bypass.
    we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; cycle();
    idle_inputs(); set_rd(5, 5); cycle();
    we = 1'b1; wr_addr = 9; wr_data = 32'h12345678; set_rd(9, 5); cycle();
    idle_inputs(); set_rd(9, 9); cycle();

    // 3: claim then retire.
    claim = 1'b1; claim_addr = 7; cycle();
    idle_inputs(); set_rd(7, 7); cycle();
    we = 1'b1; wr_addr = 7; wr_data = 32'hA5; cycle();
    idle_inputs(); cycle();

    // 4: simultaneous claim and write to the same register.
    claim = 1'b1; claim_addr = 3; we = 1'b1; wr_addr = 3; wr_data = 32'h55; set_rd(3, 7); cycle();
    idle_inputs(); set_rd(3, 3); cycle();

    // 5: register 0 on both ZERO_REG settings.
    we = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; claim = 1'b1; claim_addr = 0; set_rd(0, 1);
    cycle();
    idle_inputs(); set_rd(0, 0); cycle();

    // 6: reset mid-sweep restarts it; writes during the sweep are ignored.
    reset = 1'b1; cycle();
    reset = 1'b0;
    repeat (10) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    we = 1'b1; wr_addr = 2; wr_data = 32'hCAFEF00D; claim = 1'b1; claim_addr = 2; set_rd(2, 2);
    repeat (DEPTH) cycle();
    idle_inputs(); cycle();

    // Random traffic on a narrow address window to force collisions, with rare resets.
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 249) == 0);
      we         = $urandom_range(0, 1) == 1;
      claim      = $urandom_range(0, 2) == 0;
      wr_addr    = AW'($urandom_range(0, 7));
      claim_addr = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      if ($urandom_range(0, 9) == 0) wr_addr = AW'($urandom_range(0, DEPTH-1));
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (DEPTH + 2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
